alpha_cfg_sequencer: RTL
========================

# alpha_cfg_sequencer

Control-side companion of the HDR alpha block. Generates the `enable_sampling` strobe and owns that block's `threshold_high`, `threshold_low` and `timeout_mask` inputs. Configuration arrives over a valid/ready handshake, is validated, held in a shadow register, and committed atomically on a sample boundary. An optional guard detects alpha chatter and forces maximum timeout.

## Interface
- DIV_RATIO, 8, clk cycles per enable_sampling strobe (≥2; 8 gives 3 MHz from 24 MHz)
- RST_TH_HIGH, 9'd200, threshold_high reset value
- RST_TH_LOW, 9'd50, threshold_low reset value
- RST_TMASK, 5'b11111, timeout_mask reset value
- CHATTER_WINDOW, 64, window length in strobes (guard only)
- CHATTER_MAX, 4, alpha toggles tolerated per window (guard only)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- cfg_valid  in  1  config request
- cfg_ready  out  1  sequencer can accept a config
- cfg_th_high  in  9  requested high threshold, unsigned
- cfg_th_low  in  9  requested low threshold, unsigned
- cfg_timeout_mask  in  5  requested timeout mask
- cfg_err  out  1  1-cycle pulse: request rejected
- cfg_applied  out  1  1-cycle pulse: config committed
- alpha  in  1  alpha output of the alpha block
- enable_sampling  out  1  1-cycle sample strobe
- threshold_high  out  9  to alpha block
- threshold_low  out  9  to alpha block
- timeout_mask  out  5  to alpha block
- chatter  out  1  sticky chatter flag; tied 0 without the guard

## Operation
- Divider: `div_cnt` counts 0..DIV_RATIO-1 and wraps. `enable_sampling <= (div_cnt == DIV_RATIO-1)`.
- FSM states IDLE and PEND:
  - IDLE: `cfg_ready`=1.
  - On `cfg_valid`, validate: valid iff `cfg_th_high > cfg_th_low`.
    - Valid: latch the shadow registers, go to PEND.
    - Invalid: pulse `cfg_err` next cycle, stay in IDLE, shadow untouched.
  - PEND: `cfg_ready`=0, so further requests are back-pressured.
    - On the edge where `div_cnt == DIV_RATIO-1`, copy the shadow registers to the outputs, pulse `cfg_applied`, return to IDLE.
- All three outputs change on the same edge. No partial update is ever visible.
- Thresholds are unsigned magnitudes. No arithmetic on them beyond the compare.

## Timing
- Reset values:
  - `enable_sampling`=0, `div_cnt`=0, `cfg_ready`=1 (state IDLE), `cfg_err`=0, `cfg_applied`=0, `chatter`=0.
  - Outputs take the RST_* parameter values.
- First strobe: `enable_sampling` is high in cycle DIV_RATIO after reset deasserts, then once every DIV_RATIO cycles.
- Commit edge equals the strobe rising edge. `cfg_applied` and the new values coincide with `enable_sampling`=1, so the alpha block samples new values on that strobe.
- Accept-to-commit latency: 1..DIV_RATIO cycles.
- Handshake in the same cycle as `div_cnt == DIV_RATIO-1`: the config is not committed at that edge. It commits one full period later.
- Reset mid-PEND: the pending shadow is discarded and outputs return to RST_*.
- Reset is asynchronous: outputs go to reset values immediately, without waiting for clk.

## Configuration
- Macro `ALPHA_CHATTER_GUARD_EN`.
- Defined:
  - Register `alpha` once and count toggles, saturating. A window counter counts strobes.
  - At the end of each window (strobe with window count = CHATTER_WINDOW-1), clear both counters.
  - When the toggle count reaches CHATTER_MAX+1 within a window, set `chatter` on the next edge.
  - While `chatter`=1, drive `timeout_mask` as 5'b11111 (combinational override of the register).
  - `chatter` clears only on a `cfg_applied` commit or on reset.
- Undefined: no toggle or window logic, `chatter` tied 0, `timeout_mask` driven straight from its register.

## Structure
- Package `alpha_ctrl_pkg`: HDR_W=9, TMASK_W=5, FSM state enum {IDLE, PEND}, default threshold and mask constants.
- Sub-module `sample_strobe_gen`: the DIV_RATIO divider producing `enable_sampling` and a `last_cycle` flag (`div_cnt == DIV_RATIO-1`) used as the commit qualifier.

## Test plan
- Reset, DIV_RATIO=8 → outputs 200/50/11111. `enable_sampling` first high 8 cycles after release, then every 8 cycles.
- Request 180/40/10000 at `div_cnt`=2 → `cfg_ready` low. Commit with `cfg_applied` on the next strobe edge, all three fields changing together.
- Request at `div_cnt`=7 → no commit at that edge. Commit 8 cycles later.
- Request 50/50/00001 → `cfg_err` pulse, outputs unchanged, `cfg_ready` stays 1.
- Reset asserted while in PEND → pending config lost, outputs back to 200/50/11111.
- Guard defined, CHATTER_MAX=4: toggle `alpha` 5 times inside one window → `chatter`=1 and `timeout_mask` reads 11111. A valid commit clears `chatter` and restores the programmed mask.

Source files
------------

// File: rtl/alpha_ctrl_pkg.sv
// Shared widths, FSM state encoding and reset defaults for the HDR alpha
// control path (alpha_cfg_sequencer and its strobe generator).
package alpha_ctrl_pkg;

  localparam int HDR_W   = 9;
  localparam int TMASK_W = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [HDR_W-1:0]   DEF_TH_HIGH = 9'd200;
  localparam logic [HDR_W-1:0]   DEF_TH_LOW  = 9'd50;
  localparam logic [TMASK_W-1:0] DEF_TMASK   = 5'b11111;
  localparam logic [TMASK_W-1:0] TMASK_ALL   = 5'b11111;

  // A request is only meaningful when the band is non-empty.
  function automatic logic cfg_is_valid(input logic [HDR_W-1:0] th_high,
                                        input logic [HDR_W-1:0] th_low);
    return (th_high > th_low);
  endfunction

endpackage

// File: rtl/sample_strobe_gen.sv
// Free-running divider: enable_sampling pulses once every DIV_RATIO clocks;
// last_cycle flags the final count of each period (the commit qualifier).
module sample_strobe_gen #(
  parameter int unsigned DIV_RATIO = 8
) (
  input  logic clk,
  input  logic reset,
  output logic enable_sampling,
  output logic last_cycle
);

  localparam int CNT_W = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_RATIO - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] div_cnt_r;

  assign last_cycle = (div_cnt_r == CNT_LAST);

  // Divider counter and registered strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r       <= '0;
      enable_sampling <= 1'b0;
    end else begin
      enable_sampling <= last_cycle;
      if (last_cycle) begin
        div_cnt_r <= '0;
      end else begin
        div_cnt_r <= div_cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/alpha_cfg_sequencer.sv
// Config sequencer for the HDR alpha block: validates requests, shadows them
// and commits atomically on the sample strobe. Optional chatter guard under
// `ALPHA_CHATTER_GUARD_EN.
module alpha_cfg_sequencer
  import alpha_ctrl_pkg::*;
#(
  parameter int unsigned          DIV_RATIO      = 8,
  parameter logic [HDR_W-1:0]     RST_TH_HIGH    = DEF_TH_HIGH,
  parameter logic [HDR_W-1:0]     RST_TH_LOW     = DEF_TH_LOW,
  parameter logic [TMASK_W-1:0]   RST_TMASK      = DEF_TMASK,
  parameter int unsigned          CHATTER_WINDOW = 64,
  parameter int unsigned          CHATTER_MAX    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [HDR_W-1:0]   cfg_th_high,
  input  logic [HDR_W-1:0]   cfg_th_low,
  input  logic [TMASK_W-1:0] cfg_timeout_mask,
  output logic               cfg_err,
  output logic               cfg_applied,
  input  logic               alpha,
  output logic               enable_sampling,
  output logic [HDR_W-1:0]   threshold_high,
  output logic [HDR_W-1:0]   threshold_low,
  output logic [TMASK_W-1:0] timeout_mask,
  output logic               chatter
);

  state_t               state_r;
  logic [HDR_W-1:0]     sh_th_high_r;
  logic [HDR_W-1:0]     sh_th_low_r;
  logic [TMASK_W-1:0]   sh_tmask_r;
  logic [TMASK_W-1:0]   tmask_r;
  logic                 last_cycle_s;
  logic                 commit_s;

  sample_strobe_gen #(
    .DIV_RATIO (DIV_RATIO)
  ) u_strobe (
    .clk             (clk),
    .reset           (reset),
    .enable_sampling (enable_sampling),
    .last_cycle      (last_cycle_s)
  );

  // Commit edge coincides with the strobe rising edge.
  assign commit_s = (state_r == PEND) && last_cycle_s;

  // Handshake/commit FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      cfg_ready      <= 1'b1;
      cfg_err        <= 1'b0;
      cfg_applied    <= 1'b0;
      sh_th_high_r   <= RST_TH_HIGH;
      sh_th_low_r    <= RST_TH_LOW;
      sh_tmask_r     <= RST_TMASK;
      threshold_high <= RST_TH_HIGH;
      threshold_low  <= RST_TH_LOW;
      tmask_r        <= RST_TMASK;
    end else begin
      cfg_err     <= 1'b0;
      cfg_applied <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_is_valid(cfg_th_high, cfg_th_low)) begin
              sh_th_high_r <= cfg_th_high;
              sh_th_low_r  <= cfg_th_low;
              sh_tmask_r   <= cfg_timeout_mask;
              state_r      <= PEND;
              cfg_ready    <= 1'b0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        PEND: begin
          // A request accepted on the last cycle waits for the next period.
          if (last_cycle_s) begin
            threshold_high <= sh_th_high_r;
            threshold_low  <= sh_th_low_r;
            tmask_r        <= sh_tmask_r;
            cfg_applied    <= 1'b1;
            state_r        <= IDLE;
            cfg_ready      <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef ALPHA_CHATTER_GUARD_EN
  localparam int WIN_W = (CHATTER_WINDOW > 1) ? $clog2(CHATTER_WINDOW) : 1;
  localparam int TOG_W = $clog2(CHATTER_MAX + 2);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CHATTER_WINDOW - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [TOG_W-1:0] TOG_SAT  = TOG_W'(CHATTER_MAX + 1);
  localparam logic [TOG_W-1:0] TOG_PRE  = TOG_W'(CHATTER_MAX);
  localparam logic [TOG_W-1:0] TOG_ONE  = TOG_W'(1);

  logic             alpha_r;
  logic [WIN_W-1:0] win_cnt_r;
  logic [TOG_W-1:0] tog_cnt_r;
  logic             reach_r;
  logic             chatter_r;
  logic             toggle_s;
  logic             win_end_s;

  assign toggle_s  = alpha ^ alpha_r;
  assign win_end_s = enable_sampling && (win_cnt_r == WIN_LAST);

  // Toggle and window counters; reach_r marks the toggle that crosses the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alpha_r   <= 1'b0;
      win_cnt_r <= '0;
      tog_cnt_r <= '0;
      reach_r   <= 1'b0;
    end else begin
      alpha_r <= alpha;
      if (win_end_s) begin
        win_cnt_r <= '0;
        tog_cnt_r <= '0;
        reach_r   <= 1'b0;
      end else begin
        if (enable_sampling) begin
          win_cnt_r <= win_cnt_r + WIN_ONE;
        end
        if (toggle_s && (tog_cnt_r != TOG_SAT)) begin
          tog_cnt_r <= tog_cnt_r + TOG_ONE;
        end
        reach_r <= toggle_s && (tog_cnt_r == TOG_PRE);
      end
    end
  end

  // Sticky chatter flag; a commit takes priority so the new mask is visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chatter_r <= 1'b0;
    end else if (commit_s) begin
      chatter_r <= 1'b0;
    end else if (reach_r) begin
      chatter_r <= 1'b1;
    end
  end

  assign chatter      = chatter_r;
  assign timeout_mask = chatter_r ? TMASK_ALL : tmask_r;
`else
  localparam int unsigned unused_guard_params = CHATTER_WINDOW + CHATTER_MAX;
  logic unused_alpha_s;
  logic unused_commit_s;

  assign unused_alpha_s  = alpha;
  assign unused_commit_s = commit_s;
  assign chatter         = 1'b0;
  assign timeout_mask    = tmask_r;
`endif

endmodule
